// File: rtl/utilization_counter.sv
// rtl/utilization_counter.sv - per-layer conv-lane utilization counters with a valid/ready report port
// Optional macro UTIL_PCT_EN adds rpt_util_pct, computed by a 7-cycle restoring divider (DIV state).
module utilization_counter #(
    parameter int LANES = 9,
    parameter int CW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dataflow_en,
    input  logic [LANES-1:0] conv_vld,
    input  logic             weight_req,
    input  logic             input_loader_req,
    input  logic             layer_start,
    input  logic             layer_done,
    input  logic             rpt_rdy,
    output logic             rpt_vld,
    output logic [CW-1:0]    rpt_cycles,
    output logic [CW-1:0]    rpt_active,
    output logic [CW+3:0]    rpt_lane_sum,
    output logic [CW-1:0]    rpt_stall,
    output logic [15:0]      rpt_layer_idx,
`ifdef UTIL_PCT_EN
    output logic [6:0]       rpt_util_pct,
`endif
    output logic             busy,
    output logic             overflow
);

    localparam int LW = CW + 4;
    localparam int PW = $clog2(LANES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
`ifdef UTIL_PCT_EN
    localparam logic [1:0] ST_DIV  = 2'd3;
    localparam int         DW      = CW + 12;
`endif

    function automatic logic [PW-1:0] popcount(input logic [LANES-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) c = c + PW'(v[i]);
        return c;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d, act_q, act_d, stall_q, stall_d;
    logic [LW-1:0] lsum_q, lsum_d;
    logic [CW-1:0] r_cyc_q, r_cyc_d, r_act_q, r_act_d, r_stall_q, r_stall_d;
    logic [LW-1:0] r_lsum_q, r_lsum_d;
    logic [15:0]   idx_q, idx_d;
    logic          ovf_q, ovf_d;

`ifdef UTIL_PCT_EN
    logic [DW-1:0] num_q, num_d, den_q, den_d, den_shift;
    logic [6:0]    quo_q, quo_d, pct_q, pct_d, quo_next;
    logic [2:0]    bit_q, bit_d;
    logic          q_bit;
`endif

    // Saturating next values for a RUN cycle; each counter clamps at all-ones.
    logic          act_inc, stall_inc, lsum_sat, sat_any;
    logic [CW-1:0] cyc_nx, act_nx, stall_nx;
    logic [LW-1:0] lane_add, lsum_nx;
    logic [LW:0]   lsum_sum;

    always_comb begin
        act_inc   = dataflow_en;
        stall_inc = !dataflow_en && (weight_req || input_loader_req);
        cyc_nx    = (&cyc_q) ? cyc_q : cyc_q + CW'(1);
        act_nx    = (act_inc && !(&act_q)) ? act_q + CW'(1) : act_q;
        stall_nx  = (stall_inc && !(&stall_q)) ? stall_q + CW'(1) : stall_q;
        lane_add  = dataflow_en ? LW'(popcount(conv_vld)) : '0;
        lsum_sum  = {1'b0, lsum_q} + {1'b0, lane_add};
        lsum_sat  = lsum_sum[LW];
        lsum_nx   = lsum_sat ? '1 : lsum_sum[LW-1:0];
        sat_any   = (&cyc_q) || (act_inc && (&act_q)) || (stall_inc && (&stall_q)) || lsum_sat;
    end

`ifdef UTIL_PCT_EN
    always_comb begin
        den_shift = den_q << bit_q;
        q_bit     = (num_q >= den_shift);
        quo_next  = quo_q | (7'(q_bit) << bit_q);
    end
`endif

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        act_d     = act_q;
        stall_d   = stall_q;
        lsum_d    = lsum_q;
        r_cyc_d   = r_cyc_q;
        r_act_d   = r_act_q;
        r_stall_d = r_stall_q;
        r_lsum_d  = r_lsum_q;
        idx_d     = idx_q;
        ovf_d     = ovf_q;
`ifdef UTIL_PCT_EN
        num_d     = num_q;
        den_d     = den_q;
        quo_d     = quo_q;
        pct_d     = pct_q;
        bit_d     = bit_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (layer_start) begin
                    cyc_d   = '0;
                    act_d   = '0;
                    stall_d = '0;
                    lsum_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cyc_d   = cyc_nx;
                act_d   = act_nx;
                stall_d = stall_nx;
                lsum_d  = lsum_nx;
                ovf_d   = ovf_q || sat_any;
                if (layer_done) begin
                    r_cyc_d   = cyc_nx;
                    r_act_d   = act_nx;
                    r_stall_d = stall_nx;
                    r_lsum_d  = lsum_nx;
`ifdef UTIL_PCT_EN
                    num_d   = DW'(lsum_nx) * DW'(100);
                    den_d   = DW'(cyc_nx) * DW'(LANES);
                    quo_d   = '0;
                    bit_d   = 3'd6;
                    state_d = ST_DIV;
`else
                    state_d = ST_HOLD;
`endif
                end
            end
`ifdef UTIL_PCT_EN
            ST_DIV: begin
                if (q_bit) num_d = num_q - den_shift;
                quo_d = quo_next;
                if (bit_q == 3'd0) begin
                    pct_d   = quo_next;
                    state_d = ST_HOLD;
                end else begin
                    bit_d = bit_q - 3'd1;
                end
            end
`endif
            ST_HOLD: begin
                if (rpt_rdy) begin
                    idx_d = idx_q + 16'd1;
                    // A start coinciding with the handshake begins the next layer directly.
                    if (layer_start) begin
                        cyc_d   = '0;
                        act_d   = '0;
                        stall_d = '0;
                        lsum_d  = '0;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cyc_q     <= '0;
            act_q     <= '0;
            stall_q   <= '0;
            lsum_q    <= '0;
            r_cyc_q   <= '0;
            r_act_q   <= '0;
            r_stall_q <= '0;
            r_lsum_q  <= '0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
`ifdef UTIL_PCT_EN
            num_q     <= '0;
            den_q     <= '0;
            quo_q     <= '0;
            pct_q     <= '0;
            bit_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            act_q     <= act_d;
            stall_q   <= stall_d;
            lsum_q    <= lsum_d;
            r_cyc_q   <= r_cyc_d;
            r_act_q   <= r_act_d;
            r_stall_q <= r_stall_d;
            r_lsum_q  <= r_lsum_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
`ifdef UTIL_PCT_EN
            num_q     <= num_d;
            den_q     <= den_d;
            quo_q     <= quo_d;
            pct_q     <= pct_d;
            bit_q     <= bit_d;
`endif
        end
    end

    assign rpt_vld       = (state_q == ST_HOLD);
    assign busy          = (state_q == ST_RUN);
    assign overflow      = ovf_q;
    assign rpt_cycles    = r_cyc_q;
    assign rpt_active    = r_act_q;
    assign rpt_lane_sum  = r_lsum_q;
    assign rpt_stall     = r_stall_q;
    assign rpt_layer_idx = idx_q;
`ifdef UTIL_PCT_EN
    assign rpt_util_pct  = pct_q;
`endif

endmodule

// File: tb/tb_utilization_counter.sv
// tb/tb_utilization_counter.sv - directed self-checking bench for utilization_counter
// A second instance with CW=4 shares the stimulus and is checked for saturation.
module tb_utilization_counter;

`ifdef UTIL_PCT_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dataflow_en = 1'b0, weight_req = 1'b0, input_loader_req = 1'b0;
    logic        layer_start = 1'b0, layer_done = 1'b0, rpt_rdy = 1'b0;
    logic [8:0]  conv_vld = '0;

    logic        rpt_vld, busy, overflow;
    logic [31:0] rpt_cycles, rpt_active, rpt_stall;
    logic [35:0] rpt_lane_sum;
    logic [15:0] rpt_layer_idx;
    logic        s_rpt_vld, s_busy, s_overflow;
    logic [3:0]  s_rpt_cycles, s_rpt_active, s_rpt_stall;
    logic [7:0]  s_rpt_lane_sum;
    logic [15:0] s_rpt_layer_idx;
`ifdef UTIL_PCT_EN
    logic [6:0]  rpt_util_pct, s_rpt_util_pct;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    utilization_counter #(.LANES(9), .CW(32)) dut (
        .clk(clk), .rst(rst), .dataflow_en(dataflow_en), .conv_vld(conv_vld),
        .weight_req(weight_req), .input_loader_req(input_loader_req),
        .layer_start(layer_start), .layer_done(layer_done), .rpt_rdy(rpt_rdy),
        .rpt_vld(rpt_vld), .rpt_cycles(rpt_cycles), .rpt_active(rpt_active),
        .rpt_lane_sum(rpt_lane_sum), .rpt_stall(rpt_stall), .rpt_layer_idx(rpt_layer_idx),
`ifdef UTIL_PCT_EN
        .rpt_util_pct(rpt_util_pct),
`endif
        .busy(busy), .overflow(overflow)
    );

    utilization_counter #(.LANES(9), .CW(4)) dut_sat (
        .clk(clk), .rst(rst), .dataflow_en(dataflow_en), .conv_vld(conv_vld),
        .weight_req(weight_req), .input_loader_req(input_loader_req),
        .layer_start(layer_start), .layer_done(layer_done), .rpt_rdy(rpt_rdy),
        .rpt_vld(s_rpt_vld), .rpt_cycles(s_rpt_cycles), .rpt_active(s_rpt_active),
        .rpt_lane_sum(s_rpt_lane_sum), .rpt_stall(s_rpt_stall), .rpt_layer_idx(s_rpt_layer_idx),
`ifdef UTIL_PCT_EN
        .rpt_util_pct(s_rpt_util_pct),
`endif
        .busy(s_busy), .overflow(s_overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic start_layer();
        layer_start = 1'b1;
        step();
        layer_start = 1'b0;
    endtask

    task automatic run_cycle(input logic df, input logic [8:0] vld, input logic wreq, input logic done);
        dataflow_en = df;
        conv_vld    = vld;
        weight_req  = wreq;
        layer_done  = done;
        step();
        dataflow_en = 1'b0;
        conv_vld    = '0;
        weight_req  = 1'b0;
        layer_done  = 1'b0;
    endtask

    task automatic wait_vld(output int n);
        n = 0;
        while (!rpt_vld && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic handshake();
        rpt_rdy = 1'b1;
        step();
        rpt_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({rpt_vld, busy, overflow, rpt_cycles, rpt_active, rpt_lane_sum, rpt_stall, rpt_layer_idx} !== '0) begin
            errors++;
            $display("FAIL reset_main: vld=%0b busy=%0b ovf=%0b cyc=%0d idx=%0d, expected all 0",
                     rpt_vld, busy, overflow, rpt_cycles, rpt_layer_idx);
        end
        checks++;
        if ({s_rpt_vld, s_busy, s_overflow, s_rpt_cycles, s_rpt_layer_idx} !== '0) begin
            errors++;
            $display("FAIL reset_sat: vld=%0b busy=%0b ovf=%0b, expected all 0", s_rpt_vld, s_busy, s_overflow);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_full();
        int n;
        do_reset();
        start_layer();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL full_busy: got %0b expected 1", busy);
        end
        for (int i = 0; i < 10; i++) run_cycle(1'b1, 9'h1FF, 1'b0, i == 9);
        wait_vld(n);
        checks++;
        if (!rpt_vld || n != LAT) begin
            errors++;
            $display("FAIL full_latency: got %0d vld=%0b expected %0d", n, rpt_vld, LAT);
        end
        checks++;
        if ({rpt_cycles, rpt_active, rpt_lane_sum, rpt_stall, rpt_layer_idx} !== {32'd10, 32'd10, 36'd90, 32'd0, 16'd0}) begin
            errors++;
            $display("FAIL full_report: got %0d/%0d/%0d/%0d idx %0d expected 10/10/90/0 idx 0",
                     rpt_cycles, rpt_active, rpt_lane_sum, rpt_stall, rpt_layer_idx);
        end
`ifdef UTIL_PCT_EN
        checks++;
        if (rpt_util_pct !== 7'd100) begin
            errors++;
            $display("FAIL full_pct: got %0d expected 100", rpt_util_pct);
        end
`endif
        handshake();
        checks++;
        if ({rpt_vld, busy, rpt_layer_idx, rpt_cycles} !== {1'b0, 1'b0, 16'd1, 32'd10}) begin
            errors++;
            $display("FAIL full_handshake: vld=%0b busy=%0b idx=%0d cyc=%0d expected 0 0 1 10",
                     rpt_vld, busy, rpt_layer_idx, rpt_cycles);
        end
    endtask

    task automatic test_mixed();
        int n;
        start_layer();
        for (int i = 0; i < 20; i++) run_cycle(i % 2 == 0, 9'h00F, i % 2 == 1, i == 19);
        wait_vld(n);
        checks++;
        if ({rpt_vld, rpt_cycles, rpt_active, rpt_lane_sum, rpt_stall, rpt_layer_idx} !==
            {1'b1, 32'd20, 32'd10, 36'd40, 32'd10, 16'd1}) begin
            errors++;
            $display("FAIL mixed_report: vld=%0b got %0d/%0d/%0d/%0d idx %0d expected 20/10/40/10 idx 1",
                     rpt_vld, rpt_cycles, rpt_active, rpt_lane_sum, rpt_stall, rpt_layer_idx);
        end
`ifdef UTIL_PCT_EN
        checks++;
        if (rpt_util_pct !== 7'd22) begin
            errors++;
            $display("FAIL mixed_pct: got %0d expected 22", rpt_util_pct);
        end
`endif
        handshake();
    endtask

    task automatic test_back_to_back();
        int n;
        logic [147:0] snap;
        do_reset();
        start_layer();
        for (int i = 0; i < 4; i++) run_cycle(1'b1, 9'h003, 1'b0, i == 3);
        wait_vld(n);
        snap = {rpt_cycles, rpt_active, rpt_lane_sum, rpt_stall, rpt_layer_idx};
        checks++;
        if (snap !== {32'd4, 32'd4, 36'd8, 32'd0, 16'd0}) begin
            errors++;
            $display("FAIL bp_report: got %0d/%0d/%0d/%0d expected 4/4/8/0", rpt_cycles, rpt_active, rpt_lane_sum, rpt_stall);
        end
        for (int i = 0; i < 5; i++) begin
            layer_start = (i == 2);
            step();
            layer_start = 1'b0;
            checks++;
            if (!rpt_vld || busy || {rpt_cycles, rpt_active, rpt_lane_sum, rpt_stall, rpt_layer_idx} !== snap) begin
                errors++;
                $display("FAIL bp_hold_%0d: vld=%0b busy=%0b cyc=%0d idx=%0d expected 1 0 4 0",
                         i, rpt_vld, busy, rpt_cycles, rpt_layer_idx);
            end
        end
        rpt_rdy     = 1'b1;
        layer_start = 1'b1;
        step();
        rpt_rdy     = 1'b0;
        layer_start = 1'b0;
        checks++;
        if ({busy, rpt_vld, rpt_layer_idx} !== {1'b1, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL bp_restart: busy=%0b vld=%0b idx=%0d expected 1 0 1", busy, rpt_vld, rpt_layer_idx);
        end
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 9'h1FF, 1'b1, i == 2);
        wait_vld(n);
        checks++;
        if ({rpt_vld, rpt_cycles, rpt_active, rpt_lane_sum, rpt_stall, rpt_layer_idx} !==
            {1'b1, 32'd3, 32'd0, 36'd0, 32'd3, 16'd1}) begin
            errors++;
            $display("FAIL bp_second: vld=%0b got %0d/%0d/%0d/%0d idx %0d expected 3/0/0/3 idx 1",
                     rpt_vld, rpt_cycles, rpt_active, rpt_lane_sum, rpt_stall, rpt_layer_idx);
        end
        handshake();
    endtask

    task automatic test_saturation();
        int n;
        do_reset();
        start_layer();
        for (int i = 0; i < 20; i++) run_cycle(1'b1, 9'h000, 1'b0, i == 19);
        wait_vld(n);
        checks++;
        if ({s_rpt_vld, s_rpt_cycles, s_rpt_active, s_rpt_lane_sum, s_rpt_stall, s_overflow, s_rpt_layer_idx} !==
            {1'b1, 4'd15, 4'd15, 8'd0, 4'd0, 1'b1, 16'd0}) begin
            errors++;
            $display("FAIL sat_report: vld=%0b got %0d/%0d/%0d ovf=%0b expected 15/15/0 ovf=1",
                     s_rpt_vld, s_rpt_cycles, s_rpt_active, s_rpt_stall, s_overflow);
        end
`ifdef UTIL_PCT_EN
        checks++;
        if (s_rpt_util_pct !== 7'd0) begin
            errors++;
            $display("FAIL sat_pct: got %0d expected 0", s_rpt_util_pct);
        end
`endif
        checks++;
        if ({rpt_cycles, rpt_active, overflow} !== {32'd20, 32'd20, 1'b0}) begin
            errors++;
            $display("FAIL sat_wide: got %0d/%0d ovf=%0b expected 20/20 ovf=0", rpt_cycles, rpt_active, overflow);
        end
        handshake();
        start_layer();
        for (int i = 0; i < 2; i++) run_cycle(1'b0, 9'h000, 1'b0, i == 1);
        wait_vld(n);
        checks++;
        if ({s_rpt_cycles, s_overflow} !== {4'd2, 1'b1}) begin
            errors++;
            $display("FAIL sat_sticky: cyc=%0d ovf=%0b expected 2 1", s_rpt_cycles, s_overflow);
        end
        handshake();
        do_reset();
        checks++;
        if (s_overflow !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: ovf=%0b expected 0", s_overflow);
        end
    endtask

    task automatic test_reset_mid_layer();
        int n;
        start_layer();
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 9'h1FF, 1'b0, i == 2);
        wait_vld(n);
        handshake();
        start_layer();
        for (int i = 0; i < 4; i++) run_cycle(1'b1, 9'h1FF, 1'b0, 1'b0);
        checks++;
        if ({busy, rpt_cycles, rpt_layer_idx} !== {1'b1, 32'd3, 16'd1}) begin
            errors++;
            $display("FAIL mid_pre: busy=%0b cyc=%0d idx=%0d expected 1 3 1", busy, rpt_cycles, rpt_layer_idx);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, rpt_vld, rpt_cycles, rpt_lane_sum, rpt_layer_idx} !== '0) begin
            errors++;
            $display("FAIL mid_reset: busy=%0b vld=%0b cyc=%0d lsum=%0d idx=%0d expected all 0",
                     busy, rpt_vld, rpt_cycles, rpt_lane_sum, rpt_layer_idx);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_gating();
        int n;
        start_layer();
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 9'h1FF, 1'b0, i == 7);
        wait_vld(n);
        checks++;
        if ({rpt_vld, rpt_cycles, rpt_active, rpt_lane_sum, rpt_stall, rpt_layer_idx} !==
            {1'b1, 32'd8, 32'd0, 36'd0, 32'd0, 16'd0}) begin
            errors++;
            $display("FAIL gating_report: vld=%0b got %0d/%0d/%0d/%0d idx %0d expected 8/0/0/0 idx 0",
                     rpt_vld, rpt_cycles, rpt_active, rpt_lane_sum, rpt_stall, rpt_layer_idx);
        end
`ifdef UTIL_PCT_EN
        checks++;
        if (rpt_util_pct !== 7'd0) begin
            errors++;
            $display("FAIL gating_pct: got %0d expected 0", rpt_util_pct);
        end
`endif
        handshake();
    endtask

    initial begin
        test_reset();
        test_full();
        test_mixed();
        test_back_to_back();
        test_saturation();
        test_reset_mid_layer();
        test_gating();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
